// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard/flow-control bundle: ID-stage instruction fields and branch
// resolution in, pipeline enables, bubble/flush controls and stall statistics out.
interface hazard_ctrl_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_rs_valid;
  logic        id_rt_valid;
  logic        id_reg_write;
  logic [2:0]  id_write_reg;
  logic        id_mem_read;
  logic        id_halt;
  logic        ex_branch_taken;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        ifid_flush;
  logic        zero_control_signals;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_rs_valid, id_rt_valid, id_reg_write, id_write_reg,
           id_mem_read, id_halt, ex_branch_taken,
    input  pc_write_en, ifid_write_en, ifid_flush, zero_control_signals,
           halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_rs_valid, id_rt_valid, id_reg_write, id_write_reg,
           id_mem_read, id_halt, ex_branch_taken,
    output pc_write_en, ifid_write_en, ifid_flush, zero_control_signals,
           halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/flow control between IF/ID and ID/EX: RAW scoreboard, branch squash, HALT freeze.
// Optional macro HAZ_FORWARD_EN: full forwarding, only load-use hazards stall.
module hazard_ctrl #(
  parameter int WB_DEPTH     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [2:0] WB_CNT    = 3'(WB_DEPTH);
  localparam logic [1:0] FC_RELOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALTED} state_t;

  state_t      state_reg;
  logic [1:0]  fcnt_reg;
  logic [15:0] stall_cycles_reg;

  logic [7:0]  blocks;
  logic        raw;
  logic        issue;
  logic        pc_write_en_next;
  logic        ifid_write_en_next;
  logic        ifid_flush_next;
  logic        zcs_next;
  logic        halted_next;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sb
      logic [2:0] count_reg;
      logic       ld_reg;
      logic       set_w;

      assign set_w = issue && bus.id_reg_write && (bus.id_write_reg == 3'(gi));

      // A fresh issue overrides the drain; any decrement drops the load flag.
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= 3'd0;
          ld_reg    <= 1'b0;
        end else if (set_w) begin
          count_reg <= WB_CNT;
          ld_reg    <= bus.id_mem_read;
        end else if (count_reg != 3'd0) begin
          count_reg <= count_reg - 3'd1;
          ld_reg    <= 1'b0;
        end
      end

`ifdef HAZ_FORWARD_EN
      assign blocks[gi] = (count_reg == WB_CNT) && ld_reg;
`else
      // A fresh load is also in flight, so the load term never changes the result here.
      assign blocks[gi] = (count_reg != 3'd0) || (ld_reg && (count_reg == WB_CNT));
`endif
    end
  endgenerate

  assign raw = (bus.id_rs_valid && blocks[bus.id_rs]) ||
               (bus.id_rt_valid && blocks[bus.id_rt]);

  always_comb begin
    pc_write_en_next   = 1'b1;
    ifid_write_en_next = 1'b1;
    ifid_flush_next    = 1'b0;
    zcs_next           = 1'b0;
    halted_next        = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          ifid_flush_next = 1'b1;
          zcs_next        = 1'b1;
        end else if (raw) begin
          pc_write_en_next   = 1'b0;
          ifid_write_en_next = 1'b0;
          zcs_next           = 1'b1;
        end
      end
      ST_FLUSH: begin
        ifid_flush_next = 1'b1;
        zcs_next        = 1'b1;
      end
      ST_HALTED: begin
        pc_write_en_next   = 1'b0;
        ifid_write_en_next = 1'b0;
        zcs_next           = 1'b1;
        halted_next        = 1'b1;
      end
      default: begin
        zcs_next = 1'b1;
      end
    endcase
  end

  assign issue = !zcs_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      fcnt_reg         <= 2'd0;
      stall_cycles_reg <= 16'd0;
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_reg <= ST_FLUSH;
              fcnt_reg  <= FC_RELOAD;
            end
          end else if (raw) begin
            if (stall_cycles_reg != 16'hFFFF)
              stall_cycles_reg <= stall_cycles_reg + 16'd1;
          end else if (bus.id_halt) begin
            state_reg <= ST_HALTED;
          end
        end
        ST_FLUSH: begin
          if (bus.ex_branch_taken) begin
            fcnt_reg <= FC_RELOAD;
          end else if (fcnt_reg <= 2'd1) begin
            fcnt_reg  <= 2'd0;
            state_reg <= ST_RUN;
          end else begin
            fcnt_reg <= fcnt_reg - 2'd1;
          end
        end
        ST_HALTED: begin
          state_reg <= ST_HALTED;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_write_en          = pc_write_en_next;
  assign bus.ifid_write_en        = ifid_write_en_next;
  assign bus.ifid_flush           = ifid_flush_next;
  assign bus.zero_control_signals = zcs_next;
  assign bus.halted               = halted_next;
  assign bus.stall_cycles         = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl: a cycle-level reference model
// pushes expected outputs, an independent monitor pops and compares each cycle.
module tb_hazard_ctrl;
  localparam int WB_DEPTH     = 3;
  localparam int FLUSH_CYCLES = 2;

  logic clk;
  logic rst;
  hazard_ctrl_if bus();

  hazard_ctrl #(.WB_DEPTH(WB_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write_en, ifid_write_en, ifid_flush, zero_control_signals, halted, stall_cycles}
  logic [20:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit driver_done = 1'b0;

  // Reference model: when each register was last issued as a destination, and by what.
  int m_cyc;
  int m_issue_cyc[8];
  bit m_is_ld[8];
  int m_flush_left;
  bit m_halted;
  int m_stalls;

  function automatic bit m_busy(input bit [2:0] r);
    int k;
    k = m_cyc - m_issue_cyc[r];
`ifdef HAZ_FORWARD_EN
    return (k == 1) && m_is_ld[r];
`else
    return (k >= 1) && (k <= WB_DEPTH);
`endif
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 8; r++) begin
      m_issue_cyc[r] = -100;
      m_is_ld[r]     = 1'b0;
    end
    m_flush_left = 0;
    m_halted     = 1'b0;
    m_stalls     = 0;
  endtask

  // Applies one cycle of inputs, predicts that cycle's outputs, then advances the model past the edge.
  task automatic step(input bit rst_i, input bit br, input bit rw, input bit [2:0] wr,
                      input bit ml, input bit hl, input bit [2:0] rs, input bit rsv,
                      input bit [2:0] rt, input bit rtv);
    bit raw, pc, ifw, fl, z, h;
    rst                  = rst_i;
    bus.ex_branch_taken  = br;
    bus.id_reg_write     = rw;
    bus.id_write_reg     = wr;
    bus.id_mem_read      = ml;
    bus.id_halt          = hl;
    bus.id_rs            = rs;
    bus.id_rs_valid      = rsv;
    bus.id_rt            = rt;
    bus.id_rt_valid      = rtv;

    raw = (rsv && m_busy(rs)) || (rtv && m_busy(rt));
    pc = 1; ifw = 1; fl = 0; z = 0; h = 0;
    if (m_halted) begin
      pc = 0; ifw = 0; z = 1; h = 1;
    end else if (m_flush_left > 0 || br) begin
      fl = 1; z = 1;
    end else if (raw) begin
      pc = 0; ifw = 0; z = 1;
    end
    exp_q.push_back({pc, ifw, fl, z, h, 16'(m_stalls)});

    if (rst_i) begin
      m_reset();
    end else begin
      if (!z && rw) begin
        m_issue_cyc[wr] = m_cyc;
        m_is_ld[wr]     = ml;
      end
      if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_flush_left > 0) begin
        m_flush_left = br ? FLUSH_CYCLES - 1 : m_flush_left - 1;
      end else if (br) begin
        m_flush_left = FLUSH_CYCLES - 1;
      end else if (raw) begin
        if (m_stalls < 65535) m_stalls++;
      end else if (hl) begin
        m_halted = 1'b1;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0);
  endtask

  // Monitor: one comparison per cycle, sampled mid-cycle.
  initial begin : monitor
    logic [20:0] act, exp_v;
    int txn = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush,
               bus.zero_control_signals, bus.halted, bus.stall_cycles};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL outputs txn %0d got pc=%b ifid=%b flush=%b zcs=%b halted=%b stall=%0d required pc=%b ifid=%b flush=%b zcs=%b halted=%b stall=%0d",
                   txn, act[20], act[19], act[18], act[17], act[16], act[15:0],
                   exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
        end else begin
          $display("txn %0d pc=%b ifid=%b flush=%b zcs=%b halted=%b stall=%0d ok",
                   txn, act[20], act[19], act[18], act[17], act[16], act[15:0]);
        end
        txn++;
      end
    end
  end

  initial begin : driver
    bit hl, br, rs_t;
    int wait_cnt;
    rst = 1'b1;
    bus.ex_branch_taken = 0; bus.id_reg_write = 0; bus.id_write_reg = 0;
    bus.id_mem_read = 0; bus.id_halt = 0; bus.id_rs = 0; bus.id_rs_valid = 0;
    bus.id_rt = 0; bus.id_rt_valid = 0;
    m_cyc = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then an ALU producer followed by a dependent reader.
    idle(1);
    step(0, 0, 1, 3'd3, 0, 0, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 3'd0, 0, 0, 3'd3, 1, 3'd0, 0);
    // Load producer followed by a reader on rt.
    step(0, 0, 1, 3'd2, 1, 0, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd2, 1);
    idle(4);
    // ALU producer then immediate reader.
    step(0, 0, 1, 3'd2, 0, 0, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 0, 0, 3'd2, 1, 3'd0, 0);
    // Branch squashes an r5 writer; a later r5 reader must not stall.
    step(0, 1, 1, 3'd5, 0, 0, 3'd0, 0, 3'd0, 0);
    idle(2);
    step(0, 0, 0, 3'd0, 0, 0, 3'd5, 1, 3'd5, 1);
    // Branch coincident with a RAW hazard.
    step(0, 0, 1, 3'd1, 0, 0, 3'd0, 0, 3'd0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 3'd1, 1, 3'd0, 0);
    idle(5);
    // HALT, held across branch pulses, then reset.
    step(0, 0, 0, 3'd0, 0, 1, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 10; i++) step(0, (i % 2) == 0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0);
    step(1, 0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      hl = ($urandom_range(0, 39) == 0);
      br = ($urandom_range(0, 7) == 0);
      rs_t = m_halted ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 199) == 0);
      step(rs_t, br, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, hl,
           3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    end
    idle(1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    driver_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
